// File: rtl/aux_arb_pkg.sv
// aux_arb_pkg
//   Shared types and constants for the aux-bus arbiter slice.
//   AUX_AW / AUX_DW : default aux address / data widths
//   CNT_W           : width of the host starvation counter (STARVE_LIMIT <= 255)
//   arb_state_e     : IDLE (commands accepted) / RSP (read response pending)
//   host_cmd_t      : one host command {we, adr, dat}
package aux_arb_pkg;

  localparam int AUX_AW = 16;
  localparam int AUX_DW = 8;
  localparam int CNT_W  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RSP  = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic              we;
    logic [AUX_AW-1:0] adr;
    logic [AUX_DW-1:0] dat;
  } host_cmd_t;

endpackage

// File: rtl/aux_bus_arbiter_if.sv
// aux_bus_arbiter_if
//   Host-side command/response handshake of the aux-bus arbiter.
//   Signal suffixes are relative to the arbiter (_i = into arbiter).
//   Command : host_cmd_valid_i / host_cmd_ready_o, host_cmd_we_i,
//             host_cmd_adr_i, host_cmd_dat_i
//   Response: host_rsp_valid_o / host_rsp_ready_i, host_rsp_dat_o
//   Modports: master = host (UART debug/loader), slave = arbiter.
interface aux_bus_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 8
);

  logic          host_cmd_valid_i;
  logic          host_cmd_ready_o;
  logic          host_cmd_we_i;
  logic [AW-1:0] host_cmd_adr_i;
  logic [DW-1:0] host_cmd_dat_i;
  logic          host_rsp_valid_o;
  logic          host_rsp_ready_i;
  logic [DW-1:0] host_rsp_dat_o;

  modport master (
    output host_cmd_valid_i, host_cmd_we_i, host_cmd_adr_i, host_cmd_dat_i,
    output host_rsp_ready_i,
    input  host_cmd_ready_o, host_rsp_valid_o, host_rsp_dat_o
  );

  modport slave (
    input  host_cmd_valid_i, host_cmd_we_i, host_cmd_adr_i, host_cmd_dat_i,
    input  host_rsp_ready_i,
    output host_cmd_ready_o, host_rsp_valid_o, host_rsp_dat_o
  );

endinterface

// File: rtl/aux_arb_rsp_slot.sv
// aux_arb_rsp_slot
//   One-entry response register. load_i captures dat_i and raises valid_o
//   the next cycle; data holds stable until valid_o & ready_i.
//   Ports: clk, reset_n (async, active low), load_i, dat_i, ready_i,
//          valid_o, dat_o
module aux_arb_rsp_slot #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load_i,
  input  logic [DW-1:0] dat_i,
  input  logic          ready_i,
  output logic          valid_o,
  output logic [DW-1:0] dat_o
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_o <= 1'b0;
      dat_o   <= '0;
    end else begin
      if (load_i) begin
        valid_o <= 1'b1;
        dat_o   <= dat_i;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/aux_bus_arbiter.sv
// aux_bus_arbiter
//   Shares the aux memory port between the risc16f84 core (strobe based,
//   fixed priority, cannot stall mid-access) and the host debug/loader port
//   (valid/ready). The host is served in cycles with no CPU strobe.
//   Ports: clk, reset_n (async active low),
//          cpu_adr_i/cpu_dat_i/cpu_we_i/cpu_re_i -> cpu_dat_o, cpu_clk_en_o
//          host : aux_bus_arbiter_if.slave (command + read response)
//          mem_adr_o/mem_dat_o/mem_we_o, mem_dat_i (combinational read)
//   Optional: `define AUX_ARB_STARVE_HOLD_EN to let a starved host force a
//   one-cycle core clock-enable gap after STARVE_LIMIT blocked cycles.
module aux_bus_arbiter
  import aux_arb_pkg::*;
#(
  parameter int AW           = AUX_AW,
  parameter int DW           = AUX_DW,
  parameter int STARVE_LIMIT = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] cpu_adr_i,
  input  logic [DW-1:0] cpu_dat_i,
  output logic [DW-1:0] cpu_dat_o,
  input  logic          cpu_we_i,
  input  logic          cpu_re_i,
  output logic          cpu_clk_en_o,
  aux_bus_arbiter_if.slave host,
  output logic [AW-1:0] mem_adr_o,
  output logic [DW-1:0] mem_dat_o,
  output logic          mem_we_o,
  input  logic [DW-1:0] mem_dat_i
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  arb_state_e       state_q, state_d;
  logic             hold_q;
  logic [CNT_W-1:0] wait_cnt;
  logic             cpu_busy;
  logic             host_ready;
  logic             host_hs;
  logic             host_blocked;

  // A hold cycle masks the strobe; the core re-presents it once re-enabled.
  assign cpu_busy     = (cpu_we_i | cpu_re_i) & ~hold_q;
  assign host_ready   = ~cpu_busy & (state_q == IDLE);
  assign host_hs      = host.host_cmd_valid_i & host_ready;
  assign host_blocked = host.host_cmd_valid_i & (state_q == IDLE) & cpu_busy;

  assign host.host_cmd_ready_o = host_ready;
  assign cpu_dat_o             = mem_dat_i;
  assign cpu_clk_en_o          = ~hold_q;

  always_comb begin
    mem_adr_o = cpu_adr_i;
    mem_dat_o = cpu_dat_i;
    mem_we_o  = 1'b0;
    if (cpu_busy) begin
      mem_we_o = cpu_we_i;
    end else if (host_hs) begin
      mem_adr_o = host.host_cmd_adr_i;
      mem_dat_o = host.host_cmd_dat_i;
      mem_we_o  = host.host_cmd_we_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (host_hs && !host.host_cmd_we_i) state_d = RSP;
      RSP:     if (host.host_rsp_valid_o && host.host_rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  aux_arb_rsp_slot #(.DW(DW)) u_rsp_slot (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (host_hs & ~host.host_cmd_we_i),
    .dat_i   (mem_dat_i),
    .ready_i (host.host_rsp_ready_i),
    .valid_o (host.host_rsp_valid_o),
    .dat_o   (host.host_rsp_dat_o)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (host_hs || hold_q) begin
      wait_cnt <= '0;
    end else if (host_blocked && (wait_cnt < LIMIT)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

`ifdef AUX_ARB_STARVE_HOLD_EN
  // Fires on the last blocked cycle before the limit; ~hold_q keeps holds
  // from ever landing back to back.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) hold_q <= 1'b0;
    else          hold_q <= ~hold_q & host_blocked & (wait_cnt == LIMIT - 1'b1);
  end
`else
  assign hold_q = 1'b0;
`endif

endmodule

// File: tb/tb_aux_bus_arbiter.sv
module tb_aux_bus_arbiter;
  import aux_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] cpu_adr;
  logic [7:0]  cpu_dat_w;
  logic [7:0]  cpu_dat_r;
  logic        cpu_we;
  logic        cpu_re;
  logic        cpu_clk_en;
  logic [15:0] mem_adr;
  logic [7:0]  mem_dat_w;
  logic        mem_we;
  logic [7:0]  mem_dat_r;
  logic [7:0]  mem [0:65535];

  int n_chk  = 0;
  int n_pass = 0;

  aux_bus_arbiter_if #(.AW(16), .DW(8)) hif ();

  aux_bus_arbiter #(.AW(16), .DW(8), .STARVE_LIMIT(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cpu_adr_i    (cpu_adr),
    .cpu_dat_i    (cpu_dat_w),
    .cpu_dat_o    (cpu_dat_r),
    .cpu_we_i     (cpu_we),
    .cpu_re_i     (cpu_re),
    .cpu_clk_en_o (cpu_clk_en),
    .host         (hif.slave),
    .mem_adr_o    (mem_adr),
    .mem_dat_o    (mem_dat_w),
    .mem_we_o     (mem_we),
    .mem_dat_i    (mem_dat_r)
  );

  always #5 clk = ~clk;

  assign mem_dat_r = mem[mem_adr];
  always @(posedge clk) if (mem_we) mem[mem_adr] <= mem_dat_w;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // advance one clock, land 1 time unit after the edge for driving
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_cmd(input logic v, input host_cmd_t c);
    hif.host_cmd_valid_i = v;
    hif.host_cmd_we_i    = c.we;
    hif.host_cmd_adr_i   = c.adr;
    hif.host_cmd_dat_i   = c.dat;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    reset_n = 1'b0;
    cpu_adr = '0; cpu_dat_w = '0; cpu_we = 1'b0; cpu_re = 1'b0;
    host_cmd(1'b0, '{we: 1'b0, adr: 16'h0, dat: 8'h0});
    hif.host_rsp_ready_i = 1'b0;
    #12;
    chk("rst_rsp_valid", 32'(hif.host_rsp_valid_o), 32'd0);
    chk("rst_rsp_dat",   32'(hif.host_rsp_dat_o),   32'h00);
    chk("rst_clk_en",    32'(cpu_clk_en),           32'd1);
    chk("rst_cmd_ready", 32'(hif.host_cmd_ready_o), 32'd1);
    chk("rst_mem_we",    32'(mem_we),               32'd0);
    reset_n = 1'b1;
    tick();

    // host write 0x1234 <- 0xA5, CPU idle
    host_cmd(1'b1, '{we: 1'b1, adr: 16'h1234, dat: 8'hA5});
    #1;
    chk("wr_ready",   32'(hif.host_cmd_ready_o), 32'd1);
    chk("wr_mem_we",  32'(mem_we),               32'd1);
    chk("wr_mem_adr", 32'(mem_adr),              32'h1234);
    chk("wr_mem_dat", 32'(mem_dat_w),            32'hA5);
    tick();
    host_cmd(1'b0, '{we: 1'b0, adr: 16'h0, dat: 8'h0});
    #1;
    chk("wr_no_rsp",    32'(hif.host_rsp_valid_o), 32'd0);
    chk("wr_ready_nxt", 32'(hif.host_cmd_ready_o), 32'd1);
    chk("wr_mem_cell",  32'(mem[16'h1234]),        32'hA5);

    // host read 0x1234
    host_cmd(1'b1, '{we: 1'b0, adr: 16'h1234, dat: 8'h00});
    #1;
    chk("rd_ready",   32'(hif.host_cmd_ready_o), 32'd1);
    chk("rd_mem_adr", 32'(mem_adr),              32'h1234);
    chk("rd_mem_we",  32'(mem_we),               32'd0);
    tick();
    host_cmd(1'b0, '{we: 1'b0, adr: 16'h0, dat: 8'h0});
    #1;
    chk("rd_rsp_valid", 32'(hif.host_rsp_valid_o), 32'd1);
    chk("rd_rsp_dat",   32'(hif.host_rsp_dat_o),   32'hA5);
    chk("rd_busy",      32'(hif.host_cmd_ready_o), 32'd0);
    hif.host_rsp_ready_i = 1'b1;
    tick();
    hif.host_rsp_ready_i = 1'b0;
    #1;
    chk("rd_rsp_drop",  32'(hif.host_rsp_valid_o), 32'd0);
    chk("rd_idle_rdy",  32'(hif.host_cmd_ready_o), 32'd1);

    // CPU write and host read of 0x0010 in the same cycle: CPU wins
    cpu_we = 1'b1; cpu_adr = 16'h0010; cpu_dat_w = 8'h3C;
    host_cmd(1'b1, '{we: 1'b0, adr: 16'h0010, dat: 8'h00});
    #1;
    chk("col_ready",   32'(hif.host_cmd_ready_o), 32'd0);
    chk("col_mem_we",  32'(mem_we),               32'd1);
    chk("col_mem_adr", 32'(mem_adr),              32'h0010);
    chk("col_mem_dat", 32'(mem_dat_w),            32'h3C);
    tick();
    cpu_we = 1'b0; cpu_adr = 16'h0000; cpu_dat_w = 8'h00;
    #1;
    chk("col_cpu_landed", 32'(mem[16'h0010]),        32'h3C);
    chk("col_host_grant", 32'(hif.host_cmd_ready_o), 32'd1);
    chk("col_host_adr",   32'(mem_adr),              32'h0010);
    chk("col_cpu_dat_o",  32'(cpu_dat_r),            32'h3C);
    tick();
    // new write presented while the response is pending; must not be taken
    host_cmd(1'b1, '{we: 1'b1, adr: 16'h0020, dat: 8'h11});
    #1;
    chk("col_rsp_valid", 32'(hif.host_rsp_valid_o), 32'd1);
    chk("col_rsp_dat",   32'(hif.host_rsp_dat_o),   32'h3C);

    // response back-pressured for 5 cycles
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 32'(hif.host_rsp_valid_o), 32'd1);
      chk("bp_dat",   32'(hif.host_rsp_dat_o),   32'h3C);
      chk("bp_ready", 32'(hif.host_cmd_ready_o), 32'd0);
      chk("bp_mem_we", 32'(mem_we),              32'd0);
      tick();
      #1;
    end
    hif.host_rsp_ready_i = 1'b1;
    tick();
    hif.host_rsp_ready_i = 1'b0;
    #1;
    chk("bp_drop",    32'(hif.host_rsp_valid_o), 32'd0);
    chk("bp_accept",  32'(hif.host_cmd_ready_o), 32'd1);
    chk("bp_new_we",  32'(mem_we),               32'd1);
    chk("bp_new_adr", 32'(mem_adr),              32'h0020);
    tick();
    host_cmd(1'b0, '{we: 1'b0, adr: 16'h0, dat: 8'h0});
    #1;
    chk("bp_new_cell", 32'(mem[16'h0020]), 32'h11);

    // CPU strobing every cycle, host wants to write 0x0002 <- 0x77
    cpu_we = 1'b1; cpu_adr = 16'h0040; cpu_dat_w = 8'h55;
    host_cmd(1'b1, '{we: 1'b1, adr: 16'h0002, dat: 8'h77});
`ifdef AUX_ARB_STARVE_HOLD_EN
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("sv_blk_clk_en", 32'(cpu_clk_en),           32'd1);
      chk("sv_blk_ready",  32'(hif.host_cmd_ready_o), 32'd0);
      chk("sv_blk_adr",    32'(mem_adr),              32'h0040);
      tick();
    end
    #1;
    chk("sv_hold_clk_en", 32'(cpu_clk_en),           32'd0);
    chk("sv_hold_ready",  32'(hif.host_cmd_ready_o), 32'd1);
    chk("sv_hold_we",     32'(mem_we),               32'd1);
    chk("sv_hold_adr",    32'(mem_adr),              32'h0002);
    chk("sv_hold_dat",    32'(mem_dat_w),            32'h77);
    mem[16'h0040] = 8'h00;
    tick();
    host_cmd(1'b0, '{we: 1'b0, adr: 16'h0, dat: 8'h0});
    #1;
    chk("sv_host_cell",  32'(mem[16'h0002]), 32'h77);
    chk("sv_rel_clk_en", 32'(cpu_clk_en),    32'd1);
    chk("sv_rel_we",     32'(mem_we),        32'd1);
    chk("sv_rel_adr",    32'(mem_adr),       32'h0040);
    tick();
    #1;
    chk("sv_cpu_cell",   32'(mem[16'h0040]), 32'h55);
`else
    for (int k = 0; k < 100; k++) begin
      #1;
      chk("ns_ready",  32'(hif.host_cmd_ready_o), 32'd0);
      chk("ns_clk_en", 32'(cpu_clk_en),           32'd1);
      tick();
    end
    host_cmd(1'b0, '{we: 1'b0, adr: 16'h0, dat: 8'h0});
    #1;
    chk("ns_host_cell", 32'(mem[16'h0002]), 32'h00);
`endif
    cpu_we = 1'b0; cpu_adr = 16'h0000; cpu_dat_w = 8'h00;
    tick();

    // reset asserted while a read response is pending
    host_cmd(1'b1, '{we: 1'b0, adr: 16'h1234, dat: 8'h00});
    tick();
    host_cmd(1'b0, '{we: 1'b0, adr: 16'h0, dat: 8'h0});
    #1;
    chk("mr_rsp_valid", 32'(hif.host_rsp_valid_o), 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mr_async_valid", 32'(hif.host_rsp_valid_o), 32'd0);
    chk("mr_async_dat",   32'(hif.host_rsp_dat_o),   32'h00);
    #1;
    reset_n = 1'b1;
    tick();
    #1;
    chk("mr_ready",  32'(hif.host_cmd_ready_o), 32'd1);
    chk("mr_valid",  32'(hif.host_rsp_valid_o), 32'd0);
    chk("mr_clk_en", 32'(cpu_clk_en),           32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
